spi_ram_ctrl: RTL and testbench

- Command/data memory stage directly downstream of the SPI slave; consumes its 10-bit received words (rx_data/rx_valid) and returns read bytes (tx_data/tx_valid) for serialisation on MISO.
- Holds a single-port byte RAM plus write/read address pointers, decodes the 2-bit command field, and flags protocol sequence errors.

---
 rtl/spi_ram_if.sv | 24 ++
 rtl/spi_ram_ctrl.sv | 95 +++++++++
 tb/tb_spi_ram_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/spi_ram_if.sv
// Word/byte handshake between the SPI slave and the command/data RAM stage.
interface spi_ram_if;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       seq_err;

  modport master (
    output rx_data,
    output rx_valid,
    input  tx_data,
    input  tx_valid,
    input  seq_err
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output tx_data,
    output tx_valid,
    output seq_err
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// SPI command/data stage: byte RAM with write/read pointers,
// edge-accepted commands and registered read-back.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter bit AUTO_INC  = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  spi_ram_if.slave  bus
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 seq_err;
  logic                 rd_armed;
  logic                 rx_valid_d;

  logic                 accept;
  cmd_e                 cmd;
  logic                 wr_ok;
  logic                 rd_ok;
  logic [AW-1:0]        wr_idx;
  logic [AW-1:0]        rd_idx;

  assign accept = bus.rx_valid & ~rx_valid_d;
  assign cmd    = cmd_e'(bus.rx_data[9:8]);
  assign wr_ok  = {1'b0, wr_ptr} < DEPTH;
  assign rd_ok  = {1'b0, rd_ptr} < DEPTH;
  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // RAM has no reset; only in-range writes land
  always_ff @(posedge clk) begin
    if (accept && cmd == WR_DATA && wr_ok)
      mem[wr_idx] <= bus.rx_data[7:0];
  end

  // rx_valid_d resets high so a level already present at release is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      seq_err    <= 1'b0;
      rd_armed   <= 1'b0;
      rx_valid_d <= 1'b1;
    end else begin
      rx_valid_d <= bus.rx_valid;
      seq_err    <= 1'b0;
      if (accept) begin
        tx_valid <= 1'b0;
        unique case (cmd)
          WR_ADDR: wr_ptr <= bus.rx_data[ADDR_SIZE-1:0];
          WR_DATA: begin
            if (AUTO_INC)
              wr_ptr <= wr_ptr + ADDR_SIZE'(1);
          end
          RD_ADDR: begin
            rd_ptr   <= bus.rx_data[ADDR_SIZE-1:0];
            rd_armed <= 1'b1;
          end
          RD_DATA: begin
            if (rd_armed) begin
              tx_data  <= rd_ok ? mem[rd_idx] : 8'h00;
              tx_valid <= 1'b1;
              rd_armed <= 1'b0;
            end else begin
              seq_err  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.tx_data  = tx_data;
  assign bus.tx_valid = tx_valid;
  assign bus.seq_err  = seq_err;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench: default instance (256 deep, no auto-inc) and a
// 128-deep auto-increment instance fed identical command streams.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  spi_ram_if bus_a ();
  spi_ram_if bus_b ();

  assign bus_a.rx_data  = rx_data;
  assign bus_a.rx_valid = rx_valid;
  assign bus_b.rx_data  = rx_data;
  assign bus_b.rx_valid = rx_valid;

  spi_ram_ctrl u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  spi_ram_ctrl #(
    .MEM_DEPTH (128),
    .ADDR_SIZE (8),
    .AUTO_INC  (1'b1)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  // drive on a falling edge, hold len cycles, return on the falling
  // edge after the accept so results are already visible
  task automatic send(input logic [1:0] c, input logic [7:0] p,
                      input int len = 1);
    @(negedge clk);
    rx_data  = {c, p};
    rx_valid = 1'b1;
    repeat (len) @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    send(2'b10, a);
    send(2'b11, 8'h00);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_a_txv", bus_a.tx_valid, 1'b0);
    chk("rst_a_txd", bus_a.tx_data, 8'h00);
    chk("rst_a_err", bus_a.seq_err, 1'b0);
    chk("rst_b_txv", bus_b.tx_valid, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // read data with no read address armed
    send(2'b11, 8'h00);
    chk("ill_a_err", bus_a.seq_err, 1'b1);
    chk("ill_a_txv", bus_a.tx_valid, 1'b0);
    chk("ill_b_err", bus_b.seq_err, 1'b1);
    @(negedge clk);
    chk("ill_a_err1", bus_a.seq_err, 1'b0);
    rd(8'h05);
    chk("arm_a_txv", bus_a.tx_valid, 1'b1);
    chk("arm_a_err", bus_a.seq_err, 1'b0);

    // write then read back
    send(2'b00, 8'h3C);
    send(2'b01, 8'hA5);
    send(2'b10, 8'h3C);
    chk("rda_a_txv", bus_a.tx_valid, 1'b0);
    send(2'b11, 8'h00);
    chk("wr_a_txv", bus_a.tx_valid, 1'b1);
    chk("wr_a_txd", bus_a.tx_data, 8'hA5);
    chk("wr_a_err", bus_a.seq_err, 1'b0);
    chk("wr_b_txd", bus_b.tx_data, 8'hA5);

    // any other accept clears tx_valid, data held
    send(2'b00, 8'h10);
    chk("clr_a_txv", bus_a.tx_valid, 1'b0);
    chk("clr_a_txd", bus_a.tx_data, 8'hA5);
    chk("clr_b_txv", bus_b.tx_valid, 1'b0);

    // a second read without re-arming is illegal
    rd(8'h3C);
    send(2'b11, 8'h00);
    chk("rr_a_err", bus_a.seq_err, 1'b1);
    chk("rr_a_txv", bus_a.tx_valid, 1'b0);
    chk("rr_a_txd", bus_a.tx_data, 8'hA5);

    // long rx_valid pulse is one accept
    send(2'b00, 8'h02);
    send(2'b01, 8'h11, 5);
    send(2'b01, 8'h22);
    rd(8'h02);
    chk("long_a_m2", bus_a.tx_data, 8'h22);
    chk("long_b_m2", bus_b.tx_data, 8'h11);
    rd(8'h03);
    chk("long_b_m3", bus_b.tx_data, 8'h22);

    // out of range on the 128-deep instance
    send(2'b00, 8'h90);
    send(2'b01, 8'hFF);
    rd(8'h90);
    chk("oor_a_txd", bus_a.tx_data, 8'hFF);
    chk("oor_b_txd", bus_b.tx_data, 8'h00);
    chk("oor_b_txv", bus_b.tx_valid, 1'b1);

    // pointer wrap from 0xFF
    send(2'b00, 8'hFF);
    send(2'b01, 8'h77);
    send(2'b01, 8'h66);
    rd(8'h00);
    chk("wrap_b_m0", bus_b.tx_data, 8'h66);
    rd(8'hFF);
    chk("wrap_a_mff", bus_a.tx_data, 8'h66);

    // async reset mid-read, rx_valid high across release
    rd(8'h3C);
    chk("pre_a_txv", bus_a.tx_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_a_txv", bus_a.tx_valid, 1'b0);
    chk("ar_a_txd", bus_a.tx_data, 8'h00);
    chk("ar_b_txv", bus_b.tx_valid, 1'b0);
    rx_data  = {2'b11, 8'h00};
    rx_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rel_a_err", bus_a.seq_err, 1'b0);
    end
    rx_valid = 1'b0;
    @(negedge clk);
    send(2'b11, 8'h00);
    chk("post_a_err", bus_a.seq_err, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
